// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        SKID  = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FLUSH_NONE  = 2'b00;
    localparam logic [1:0] FLUSH_ID_EX = 2'b01;
    localparam logic [1:0] FLUSH_IF_ID = 2'b10;

    localparam logic [1:0] PCSRC2_SEQ = 2'b00;
    localparam logic [1:0] PCSRC2_J   = 2'b01;
    localparam logic [1:0] PCSRC2_JR  = 2'b10;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between fetch and memory.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Redirect target selection and sequential pc+4 for the fetch stage.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            pc_src1,
    input  logic [1:0]      pc_src2,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] jr_target,
    input  logic [XLEN-1:0] cur_pc,
    input  logic [XLEN-1:0] seq_base,
    output logic [XLEN-1:0] redirect_pc_c,
    output logic [XLEN-1:0] seq_pc_c
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Jumps take precedence over a taken branch; no target keeps the current pc.
    always_comb begin
        redirect_pc_c = cur_pc;
        if (pc_src2 == PCSRC2_J) begin
            redirect_pc_c = jump_target & ALIGN_MASK;
        end else if (pc_src2 == PCSRC2_JR) begin
            redirect_pc_c = jr_target & ALIGN_MASK;
        end else if (pc_src1) begin
            redirect_pc_c = branch_target & ALIGN_MASK;
        end
    end

    assign seq_pc_c = (seq_base & ALIGN_MASK) + XLEN'(4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, skid entry
// and IF/ID register. Optional counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            keep_PC,
    input  logic            keep_IF_ID,
    input  logic [1:0]      flush,
    input  logic            RF_PCSrc1,
    input  logic [1:0]      RF_PCSrc2,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] jr_target,
    fetch_stage_if.master   bus,
    output logic [XLEN-1:0] IF_ID_Instruction,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_PC_plus4,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_imem_wait
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc_plus4;

    logic            redirect;
    logic            imem_req_c;
    logic            accept;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] seq_pc;

    assign redirect   = (flush & FLUSH_IF_ID) != FLUSH_NONE;
    assign fetch_addr = (state == FETCH) ? pc : req_addr;

    // Request is held high with a stable address once issued, until ready.
    always_comb begin
        imem_req_c = 1'b0;
        case (state)
            FETCH:       imem_req_c = !keep_PC && !redirect;
            WAIT, DRAIN: imem_req_c = 1'b1;
            default:     imem_req_c = 1'b0;
        endcase
        if (reset) begin
            imem_req_c = 1'b0;
        end
    end

    assign accept = imem_req_c && bus.imem_ready && (state == FETCH || state == WAIT);

    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = fetch_addr;

    fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc_src1       (RF_PCSrc1),
        .pc_src2       (RF_PCSrc2),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .cur_pc        (pc),
        .seq_base      (fetch_addr),
        .redirect_pc_c (redirect_pc),
        .seq_pc_c      (seq_pc)
    );

    // Fetch FSM, PC, outstanding request address and skid entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC & ALIGN_MASK;
            req_addr      <= '0;
            skid_instr    <= '0;
            skid_pc       <= '0;
            skid_pc_plus4 <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (accept) begin
                        pc <= seq_pc;
                        if (keep_IF_ID) begin
                            skid_instr    <= bus.imem_rdata;
                            skid_pc       <= fetch_addr;
                            skid_pc_plus4 <= seq_pc;
                            state         <= SKID;
                        end
                    end else if (imem_req_c) begin
                        req_addr <= pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // A response in the same cycle closes the request; otherwise drain it.
                        pc    <= redirect_pc;
                        state <= bus.imem_ready ? FETCH : DRAIN;
                    end else if (accept) begin
                        pc <= seq_pc;
                        if (keep_IF_ID) begin
                            skid_instr    <= bus.imem_rdata;
                            skid_pc       <= fetch_addr;
                            skid_pc_plus4 <= seq_pc;
                            state         <= SKID;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (bus.imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!keep_IF_ID) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

    // IF/ID register: redirect bubbles, keep holds, else load completion or skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_Instruction <= XLEN'(NOP_INSTR);
            IF_ID_PC          <= '0;
            IF_ID_PC_plus4    <= XLEN'(4);
            IF_ID_valid       <= 1'b0;
        end else if (redirect) begin
            IF_ID_Instruction <= XLEN'(NOP_INSTR);
            IF_ID_valid       <= 1'b0;
        end else if (keep_IF_ID) begin
            IF_ID_valid <= IF_ID_valid;
        end else if (accept) begin
            IF_ID_Instruction <= bus.imem_rdata;
            IF_ID_PC          <= fetch_addr;
            IF_ID_PC_plus4    <= seq_pc;
            IF_ID_valid       <= 1'b1;
        end else if (state == SKID) begin
            IF_ID_Instruction <= skid_instr;
            IF_ID_PC          <= skid_pc;
            IF_ID_PC_plus4    <= skid_pc_plus4;
            IF_ID_valid       <= 1'b1;
        end else begin
            IF_ID_Instruction <= XLEN'(NOP_INSTR);
            IF_ID_valid       <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating stall, redirect and memory-wait counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
            perf_imem_wait    <= '0;
        end else begin
            if (keep_PC && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect && perf_redirects != '1) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if ((state == WAIT || state == DRAIN) && perf_imem_wait != '1) begin
                perf_imem_wait <= perf_imem_wait + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected IF/ID PCs plus
// directed checks of handshake, bubbles and reset. FETCH_PERF_CNT_EN adds counter checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        keep_PC;
    logic        keep_IF_ID;
    logic [1:0]  flush;
    logic        RF_PCSrc1;
    logic [1:0]  RF_PCSrc2;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_plus4;
    logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
    logic [31:0] perf_imem_wait;
`endif

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .keep_PC           (keep_PC),
        .keep_IF_ID        (keep_IF_ID),
        .flush             (flush),
        .RF_PCSrc1         (RF_PCSrc1),
        .RF_PCSrc2         (RF_PCSrc2),
        .branch_target     (branch_target),
        .jump_target       (jump_target),
        .jr_target         (jr_target),
        .bus               (bus),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_PC_plus4    (IF_ID_PC_plus4),
        .IF_ID_valid       (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects),
        .perf_imem_wait    (perf_imem_wait)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory model: ready after mem_lat waiting cycles, data = addr ^ FFFF0000.
    int unsigned mem_lat  = 0;
    int unsigned wait_cnt = 0;
    assign bus.imem_ready = bus.imem_req && (wait_cnt >= mem_lat);
    assign bus.imem_rdata = bus.imem_addr ^ 32'hFFFF_0000;

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ready) wait_cnt <= wait_cnt + 1;
        else                                  wait_cnt <= 0;
    end

    // Scoreboard: expected IF/ID PCs; compared whenever a new valid entry appears.
    logic [31:0] sbq[$];
    logic [31:0] mon_pc;
    logic        held_q;

    always @(posedge clk) held_q <= keep_IF_ID && !flush[1];

    always @(negedge clk) begin
        if (!reset && IF_ID_valid && !held_q) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'(sbq.size()), 32'd1);
            end else begin
                mon_pc = sbq.pop_front();
                chk("if_id_pc", IF_ID_PC, mon_pc);
                chk("if_id_instr", IF_ID_Instruction, mon_pc ^ 32'hFFFF_0000);
                chk("if_id_pc4", IF_ID_PC_plus4, mon_pc + 32'd4);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_jump(input logic [31:0] tgt);
        RF_PCSrc2   = 2'b01;
        jump_target = tgt;
        flush       = 2'b10;
    endtask

    task automatic clear_redirect();
        RF_PCSrc1 = 1'b0;
        RF_PCSrc2 = 2'b00;
        flush     = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; keep_PC = 1'b0; keep_IF_ID = 1'b0; flush = 2'b00;
        RF_PCSrc1 = 1'b0; RF_PCSrc2 = 2'b00;
        branch_target = '0; jump_target = '0; jr_target = '0;
        repeat (2) tick();
        // Reset state
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_instr", IF_ID_Instruction, 32'h0);
        chk("rst_pc", IF_ID_PC, 32'h0);
        chk("rst_pc4", IF_ID_PC_plus4, 32'h4);

        // Scenario 1: zero-wait streaming from reset
        reset = 1'b0;
        sbq.push_back(32'h3000);
        sbq.push_back(32'h3004);
        #1;
        chk("s1_addr", bus.imem_addr, 32'h3000);
        chk("s1_req", 32'(bus.imem_req), 32'd1);
        tick();
        chk("s1_valid", 32'(IF_ID_valid), 32'd1);
        tick();

        // Scenario 2: stall both PC and IF/ID for two cycles at pc 0x3008
        keep_PC = 1'b1; keep_IF_ID = 1'b1;
        #1;
        chk("s2_req_off", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s2_hold_pc", IF_ID_PC, 32'h3004);
            chk("s2_hold_valid", 32'(IF_ID_valid), 32'd1);
        end
        keep_PC = 1'b0; keep_IF_ID = 1'b0;
        sbq.push_back(32'h3008);
        #1;
        chk("s2_addr", bus.imem_addr, 32'h3008);
        tick();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cycles, 32'd2);
`endif

        // Scenario 3: jump redirect, one bubble
        set_jump(32'h4000);
        #1;
        chk("s3_req_off", 32'(bus.imem_req), 32'd0);
        tick();
        chk("s3_bubble", 32'(IF_ID_valid), 32'd0);
        clear_redirect();
        sbq.push_back(32'h4000);
        tick();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_redir", perf_redirects, 32'd1);
`endif

        // Scenario 4: slow fetch of 0x3010 made stale by a branch redirect
        set_jump(32'h3010);
        tick();
        clear_redirect();
        mem_lat = 3;
        #1;
        chk("s4_addr", bus.imem_addr, 32'h3010);
        tick();
        flush = 2'b10; RF_PCSrc1 = 1'b1; branch_target = 32'h3100;
        tick();
        clear_redirect();
        #1;
        chk("s4_drain_req", 32'(bus.imem_req), 32'd1);
        chk("s4_drain_addr", bus.imem_addr, 32'h3010);
        chk("s4_drain_bub", 32'(IF_ID_valid), 32'd0);
        tick();
        chk("s4_drain_bub2", 32'(IF_ID_valid), 32'd0);
        tick();
        mem_lat = 0;
        #1;
        chk("s4_new_addr", bus.imem_addr, 32'h3100);
        chk("s4_new_req", 32'(bus.imem_req), 32'd1);
        chk("s4_discard", 32'(IF_ID_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_wait", perf_imem_wait, 32'd3);
`endif
        sbq.push_back(32'h3100);
        tick();

        // Redirect together with keep_IF_ID: redirect must win
        set_jump(32'h3020);
        keep_IF_ID = 1'b1;
        tick();
        chk("prio_bubble", 32'(IF_ID_valid), 32'd0);
        clear_redirect();

        // Scenario 5: fetch of 0x3020 completes while IF/ID is frozen
        #1;
        chk("s5_addr", bus.imem_addr, 32'h3020);
        tick();
        #1;
        chk("s5_skid_req", 32'(bus.imem_req), 32'd0);
        chk("s5_skid_valid", 32'(IF_ID_valid), 32'd0);
        keep_IF_ID = 1'b0;
        sbq.push_back(32'h3020);
        tick();
        #1;
        chk("s5_next_addr", bus.imem_addr, 32'h3024);
        // flush = 01 targets ID/EX only and must not disturb fetch
        flush = 2'b01;
        sbq.push_back(32'h3024);
        #1;
        chk("s5_flush01_req", 32'(bus.imem_req), 32'd1);
        tick();
        flush = 2'b00;

        // Reset asserted while a slow fetch is outstanding
        mem_lat = 2;
        #1;
        chk("rw_addr", bus.imem_addr, 32'h3028);
        tick();
        reset = 1'b1;
        #1;
        chk("rw_req", 32'(bus.imem_req), 32'd0);
        chk("rw_valid", 32'(IF_ID_valid), 32'd0);
        chk("rw_pc4", IF_ID_PC_plus4, 32'h4);
        tick();
        reset = 1'b0;
        mem_lat = 0;
        sbq.push_back(32'h3000);
        #1;
        chk("rw_restart_addr", bus.imem_addr, 32'h3000);
        chk("rw_restart_req", 32'(bus.imem_req), 32'd1);
        tick();
        keep_PC = 1'b1; keep_IF_ID = 1'b1;
        tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
